// File: rtl/mdr_pkg.sv
// Shared types and constants for the MDR arithmetic datapath.
// Op codes and core FSM state encodings.
package mdr_pkg;

    localparam int MDR_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ITER,
        FIX,
        DONE,
        ERR
    } core_state_e;

endpackage

// File: rtl/mdr_arith_core_sign_fix.sv
// Magnitude extraction of the operands and final sign application
// of the iterated magnitudes for multiply and divide.
module mdr_sign_fix
    import mdr_pkg::*;
#(
    parameter int WIDTH = MDR_WIDTH
) (
    input  op_e                  op,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH/2-1:0]   root,
    input  logic [WIDTH-1:0]     sq_rem,
    output logic [WIDTH-1:0]     mag_x,
    output logic [WIDTH-1:0]     mag_y,
    output logic [2*WIDTH-1:0]   res,
    output logic [WIDTH-1:0]     rem
);

    logic                neg;
    logic [2*WIDTH-1:0]  quo;

    assign mag_x = x[WIDTH-1] ? -x : x;
    assign mag_y = y[WIDTH-1] ? -y : y;
    assign neg   = x[WIDTH-1] ^ y[WIDTH-1];
    assign quo   = {{WIDTH{1'b0}}, acc[WIDTH-1:0]};

    always_comb begin
        res = '0;
        rem = '0;
        unique case (op)
            OP_MUL: begin
                res = neg ? -acc : acc;
            end
            OP_DIV: begin
                // quotient truncates toward zero; remainder follows dividend
                res = neg ? -quo : quo;
                rem = x[WIDTH-1] ? -acc[2*WIDTH-1:WIDTH]
                                 : acc[2*WIDTH-1:WIDTH];
            end
            OP_SQRT: begin
                res = (2*WIDTH)'(root);
                rem = sq_rem;
            end
            default: begin
                res = '0;
                rem = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdr_arith_core.sv
// Iterative signed multiply / divide / square-root datapath,
// one radix-2 step per clock, started by an enable rising edge.
module mdr_arith_core
    import mdr_pkg::*;
#(
    parameter int WIDTH = MDR_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync_clr,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 load_x,
    input  logic                 load_y,
    input  logic                 load_op,
    input  logic                 enable_operacion,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 ready,
    output logic                 error,
    output logic                 busy
);

    localparam int HW = WIDTH / 2;

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_CHECK = 3'(CHECK);
    localparam logic [2:0] S_ITER  = 3'(ITER);
    localparam logic [2:0] S_FIX   = 3'(FIX);
    localparam logic [2:0] S_DONE  = 3'(DONE);
    localparam logic [2:0] S_ERR   = 3'(ERR);

    logic [2:0]          state;
    logic [WIDTH-1:0]    x_q;
    logic [WIDTH-1:0]    y_q;
    op_e                 op_q;
    logic                en_q;
    logic [CNT_W-1:0]    cnt;
    logic [2*WIDTH-1:0]  acc;
    logic [WIDTH-1:0]    dvs;
    logic [HW-1:0]       root;
    logic [WIDTH:0]      srem;

    logic                start;
    logic                chk_err;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_diff;
    logic [WIDTH:0]      sq_rs;
    logic [WIDTH:0]      sq_nr;
    logic [WIDTH-1:0]    sq_rem;
    logic [WIDTH-1:0]    mag_x;
    logic [WIDTH-1:0]    mag_y;
    logic [2*WIDTH-1:0]  fix_res;
    logic [WIDTH-1:0]    fix_rem;

    assign start = enable_operacion & ~en_q;
    assign busy  = (state != S_IDLE);
    assign ready = (state == S_DONE);
    assign error = (state == S_ERR);

    assign chk_err = (op_q == OP_ILL)
                   | ((op_q == OP_DIV) & (y_q == '0))
                   | ((op_q == OP_SQRT) & x_q[WIDTH-1]);

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, dvs} : '0);
    assign div_diff = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, dvs};

    // non-restoring root: partial remainder is signed, radicand shifts out 2 bits per step
    assign sq_rs  = (srem << 2) | {{(WIDTH-1){1'b0}}, acc[WIDTH-1:WIDTH-2]};
    assign sq_nr  = srem[WIDTH] ? sq_rs + (WIDTH+1)'({root, 2'b11})
                                : sq_rs - (WIDTH+1)'({root, 2'b01});
    assign sq_rem = WIDTH'(srem[WIDTH] ? srem + (WIDTH+1)'({root, 1'b1})
                                       : srem);

    mdr_sign_fix #(
        .WIDTH(WIDTH)
    ) u_sign_fix (
        .op     (op_q),
        .x      (x_q),
        .y      (y_q),
        .acc    (acc),
        .root   (root),
        .sq_rem (sq_rem),
        .mag_x  (mag_x),
        .mag_y  (mag_y),
        .res    (fix_res),
        .rem    (fix_rem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            op_q      <= OP_MUL;
            en_q      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            dvs       <= '0;
            root      <= '0;
            srem      <= '0;
            result    <= '0;
            remainder <= '0;
        end else if (sync_clr) begin
            state     <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            op_q      <= OP_MUL;
            en_q      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            dvs       <= '0;
            root      <= '0;
            srem      <= '0;
            result    <= '0;
            remainder <= '0;
        end else begin
            en_q <= enable_operacion;
            unique case (state)
                S_IDLE: begin
                    if (load_x)  x_q  <= data_in;
                    if (load_y)  y_q  <= data_in;
                    if (load_op) op_q <= op_e'(data_in[1:0]);
                    if (start)   state <= S_CHECK;
                end
                S_CHECK: begin
                    if (chk_err) begin
                        state <= S_ERR;
                    end else begin
                        state <= S_ITER;
                        cnt   <= (op_q == OP_SQRT) ? CNT_W'(HW) : CNT_W'(WIDTH);
                        acc   <= {{WIDTH{1'b0}}, mag_x};
                        dvs   <= mag_y;
                        root  <= '0;
                        srem  <= '0;
                    end
                end
                S_ITER: begin
                    cnt <= cnt - CNT_W'(1);
                    case (op_q)
                        OP_MUL: acc <= {mul_sum, acc[WIDTH-1:1]};
                        OP_DIV: begin
                            if (div_diff[WIDTH])
                                acc <= {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1],
                                        acc[WIDTH-2:0], 1'b0};
                            else
                                acc <= {div_diff[WIDTH-1:0],
                                        acc[WIDTH-2:0], 1'b1};
                        end
                        default: begin
                            acc  <= acc << 2;
                            srem <= sq_nr;
                            root <= {root[HW-2:0], ~sq_nr[WIDTH]};
                        end
                    endcase
                    if (cnt == CNT_W'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    result    <= fix_res;
                    remainder <= fix_rem;
                    state     <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_arith_core.sv
// Directed-vector bench for mdr_arith_core: latency, results,
// error pulses, abort by sync_clr / rst, and level-held enable.
module tb_mdr_arith_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sync_clr = 1'b0;
    logic [15:0] data_in = '0;
    logic        load_x = 1'b0;
    logic        load_y = 1'b0;
    logic        load_op = 1'b0;
    logic        enable_operacion = 1'b0;
    logic [31:0] result;
    logic [15:0] remainder;
    logic        ready;
    logic        error;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdr_arith_core dut (
        .clk              (clk),
        .rst              (rst),
        .sync_clr         (sync_clr),
        .data_in          (data_in),
        .load_x           (load_x),
        .load_y           (load_y),
        .load_op          (load_op),
        .enable_operacion (enable_operacion),
        .result           (result),
        .remainder        (remainder),
        .ready            (ready),
        .error            (error),
        .busy             (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic load_ops(input logic [15:0] xv, input logic [15:0] yv,
                            input logic [1:0] ov);
        @(negedge clk);
        data_in = xv;
        load_x  = 1'b1;
        @(negedge clk);
        load_x  = 1'b0;
        data_in = yv;
        load_y  = 1'b1;
        @(negedge clk);
        load_y  = 1'b0;
        data_in = {14'd0, ov};
        load_op = 1'b1;
        @(negedge clk);
        load_op = 1'b0;
        data_in = '0;
    endtask

    // raise enable, watch 24 cycles, record first ready/error cycle and pulse counts
    task automatic fire(output int rc, output int ec, output int nr,
                        output int ne);
        rc = 0; ec = 0; nr = 0; ne = 0;
        enable_operacion = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                nr++;
                if (rc == 0) rc = k;
            end
            if (error) begin
                ne++;
                if (ec == 0) ec = k;
            end
        end
        @(negedge clk);
        enable_operacion = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_vec(input string tag, input logic [15:0] xv,
                          input logic [15:0] yv, input logic [1:0] ov,
                          input int exp_rc, input logic [31:0] exp_res,
                          input logic [15:0] exp_rem);
        int rc, ec, nr, ne;
        load_ops(xv, yv, ov);
        fire(rc, ec, nr, ne);
        chk({tag, ".cyc"}, 64'(rc), 64'(exp_rc));
        chk({tag, ".res"}, 64'(result), 64'(exp_res));
        chk({tag, ".rem"}, 64'(remainder), 64'(exp_rem));
        chk({tag, ".nrdy"}, 64'(nr), 64'd1);
        chk({tag, ".nerr"}, 64'(ne), 64'd0);
    endtask

    task automatic err_vec(input string tag, input logic [15:0] xv,
                           input logic [15:0] yv, input logic [1:0] ov,
                           input logic [31:0] prev_res,
                           input logic [15:0] prev_rem);
        int rc, ec, nr, ne;
        load_ops(xv, yv, ov);
        fire(rc, ec, nr, ne);
        chk({tag, ".ecyc"}, 64'(ec), 64'd2);
        chk({tag, ".nerr"}, 64'(ne), 64'd1);
        chk({tag, ".nrdy"}, 64'(nr), 64'd0);
        chk({tag, ".res"}, 64'(result), 64'(prev_res));
        chk({tag, ".rem"}, 64'(remainder), 64'(prev_rem));
    endtask

    initial begin
        int rc, ec, nr, ne;

        repeat (2) @(negedge clk);
        chk("rst.res", 64'(result), 64'd0);
        chk("rst.rem", 64'(remainder), 64'd0);
        chk("rst.flags", 64'({ready, error, busy}), 64'd0);
        rst = 1'b1;

        do_vec("mul7m3", 16'd7, 16'hFFFD, 2'b00, 19, 32'hFFFFFFEB, 16'h0000);
        do_vec("mul0", 16'd0, 16'hFFFD, 2'b00, 19, 32'h0, 16'h0);
        do_vec("mulmin", 16'h8000, 16'h8000, 2'b00, 19, 32'h40000000, 16'h0);
        do_vec("mulmix", 16'h7FFF, 16'h8000, 2'b00, 19, 32'hC0008000, 16'h0);

        do_vec("div8000", 16'h8000, 16'hFFFF, 2'b01, 19, 32'h00008000, 16'h0);
        do_vec("div100", 16'd100, 16'd7, 2'b01, 19, 32'd14, 16'd2);
        do_vec("divn100", 16'hFF9C, 16'd7, 2'b01, 19, 32'hFFFFFFF2, 16'hFFFE);
        do_vec("div100n", 16'd100, 16'hFFF9, 2'b01, 19, 32'hFFFFFFF2, 16'd2);
        do_vec("divm7", 16'hFFF9, 16'd2, 2'b01, 19, 32'hFFFFFFFD, 16'hFFFF);

        err_vec("div0", 16'd5, 16'd0, 2'b01, 32'hFFFFFFFD, 16'hFFFF);
        err_vec("sqrtm4", 16'hFFFC, 16'd0, 2'b10, 32'hFFFFFFFD, 16'hFFFF);
        err_vec("opill", 16'd9, 16'd3, 2'b11, 32'hFFFFFFFD, 16'hFFFF);
        err_vec("sqrtffff", 16'hFFFF, 16'd0, 2'b10, 32'hFFFFFFFD, 16'hFFFF);

        do_vec("sqrt1000", 16'd1000, 16'd0, 2'b10, 11, 32'd31, 16'd39);
        do_vec("sqrt7fff", 16'h7FFF, 16'd0, 2'b10, 11, 32'd181, 16'd6);
        do_vec("sqrt0", 16'd0, 16'd0, 2'b10, 11, 32'd0, 16'd0);

        // level-held enable: one ready; loads during busy must not land
        load_ops(16'd3, 16'd5, 2'b00);
        enable_operacion = 1'b1;
        nr = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ready) nr++;
            if (k == 1) chk("hold.busy", 64'(busy), 64'd1);
            if (k >= 2 && k <= 15) begin
                data_in = 16'hFFFF;
                load_x  = k[0];
            end else begin
                load_x  = 1'b0;
                data_in = '0;
            end
        end
        chk("hold.nrdy", 64'(nr), 64'd1);
        chk("hold.res", 64'(result), 64'd15);
        @(negedge clk);
        enable_operacion = 1'b0;
        @(negedge clk);
        fire(rc, ec, nr, ne);
        chk("hold.rerun", 64'(result), 64'd15);

        // sync_clr mid-iteration
        load_ops(16'd7, 16'hFFFD, 2'b00);
        enable_operacion = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        sync_clr = 1'b1;
        enable_operacion = 1'b0;
        @(posedge clk);
        #1;
        chk("clr.busy", 64'(busy), 64'd0);
        chk("clr.res", 64'(result), 64'd0);
        chk("clr.rem", 64'(remainder), 64'd0);
        chk("clr.flags", 64'({ready, error}), 64'd0);
        @(negedge clk);
        sync_clr = 1'b0;
        nr = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (ready) nr++;
        end
        chk("clr.nrdy", 64'(nr), 64'd0);

        // asynchronous reset mid-iteration
        do_vec("pre_rst", 16'd7, 16'hFFFD, 2'b00, 19, 32'hFFFFFFEB, 16'h0);
        load_ops(16'd7, 16'hFFFD, 2'b00);
        enable_operacion = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.res", 64'(result), 64'd0);
        enable_operacion = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_vec("post_rst", 16'hFFF9, 16'd2, 2'b01, 19, 32'hFFFFFFFD, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
